// File: rtl/pll_rst_seq.sv
// Reset sequencer behind the PLL: synchronises lock, waits for a stable lock window,
// then releases staged active-low resets in order and raises ready.
module pll_rst_seq #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned LOCK_STABLE_CYC = 1024,
    parameter int unsigned STAGE_GAP_CYC   = 16,
    parameter int unsigned NUM_STAGES      = 3,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  soft_rst,
    output logic [NUM_STAGES-1:0] rst_stage_n,
    output logic                  ready,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      lock_loss_cnt
);

    localparam int unsigned STAB_W = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
    localparam int unsigned GAP_W  = (STAGE_GAP_CYC > 1) ? $clog2(STAGE_GAP_CYC) : 1;

    localparam logic [STAB_W-1:0]     STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(STAGE_GAP_CYC - 1);
    localparam logic [NUM_STAGES-1:0] FIRST_REL = NUM_STAGES'(1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STABLE  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic                   lock_d_q;
    logic                   lock_fall;

    state_e                 state_q, state_d;
    logic [STAB_W-1:0]      stab_q, stab_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [NUM_STAGES-1:0]  stage_q, stage_d;
    logic                   ready_q, ready_d;
    logic [CNT_W-1:0]       loss_q;

    // Lock synchroniser; nothing else looks at pll_locked.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            lock_d_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            lock_d_q <= lock_s;
        end
    end

    assign lock_s    = sync_q[SYNC_STAGES-1];
    assign lock_fall = lock_d_q & ~lock_s;

    // Saturating lock-loss event counter, counts every falling edge of lock_s.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (lock_fall && (loss_q != CNT_MAX)) begin
            loss_q <= loss_q + CNT_W'(1);
        end
    end

    // FSM and sequencing state registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stab_q  <= '0;
            gap_q   <= '0;
            stage_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            gap_q   <= gap_d;
            stage_q <= stage_d;
            ready_q <= ready_d;
        end
    end

    // Next-state and next-output logic; lock loss outranks soft reset.
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        gap_d   = gap_q;
        stage_d = stage_q;
        ready_d = ready_q;

        unique case (state_q)
            ST_IDLE: begin
                stab_d  = '0;
                gap_d   = '0;
                stage_d = '0;
                ready_d = 1'b0;
                if (lock_s) begin
                    state_d = ST_STABLE;
                end
            end
            ST_STABLE: begin
                if (stab_q == STAB_LAST) begin
                    stab_d  = '0;
                    gap_d   = '0;
                    stage_d = FIRST_REL;
                    if (NUM_STAGES == 1) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
            ST_RELEASE: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    stage_d = NUM_STAGES'({stage_q, 1'b1});
                    if (&stage_d) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_RUN: begin
                stage_d = '1;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE) begin
            if (!lock_s) begin
                state_d = ST_IDLE;
                stab_d  = '0;
                gap_d   = '0;
                stage_d = '0;
                ready_d = 1'b0;
            end else if (soft_rst) begin
                state_d = ST_STABLE;
                stab_d  = '0;
                gap_d   = '0;
                stage_d = '0;
                ready_d = 1'b0;
            end
        end
    end

    assign rst_stage_n   = stage_q;
    assign ready         = ready_q;
    assign state         = state_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

Reset sequencer directly downstream of the PLL clock stage. It synchronises the PLL's asynchronous lock indication and waits for lock to be stable for a programmable time. It then releases a set of staged active-low resets one after another and flags `ready` to the rest of the design. Loss of lock or a soft-reset request re-asserts every downstream reset and restarts the sequence.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of the `pll_locked` synchroniser (≥2).
- `LOCK_STABLE_CYC`, 1024: consecutive synchronised-locked cycles required before the first release (≥1).
- `STAGE_GAP_CYC`, 16: cycles between successive stage releases (≥1).
- `NUM_STAGES`, 3: number of staged reset outputs (≥1).
- `CNT_W`, 8: width of the lock-loss counter.

Ports:
- `sys_clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset for the whole block.
- `pll_locked`, in, 1: PLL lock, asynchronous to `sys_clk`.
- `soft_rst`, in, 1: synchronous single-cycle request to restart the sequence.
- `rst_stage_n`, out, NUM_STAGES: staged resets, active-low; bit 0 releases first.
- `ready`, out, 1: high once every stage is released.
- `state`, out, 2: FSM state, for debug.
- `lock_loss_cnt`, out, CNT_W: saturating count of lock-loss events.

## Operation
- `lock_s` is `pll_locked` after `SYNC_STAGES` flops. No other logic samples `pll_locked`.
- FSM states and encodings:
  - IDLE = 0: all resets asserted; leave for STABLE when `lock_s` is 1.
  - STABLE = 1: a counter counts locked cycles. When the count reaches `LOCK_STABLE_CYC`, go to RELEASE and release `rst_stage_n[0]` on the same edge.
  - RELEASE = 2: release the next stage every `STAGE_GAP_CYC` cycles. On the edge that releases bit `NUM_STAGES-1`, set `ready` and go to RUN.
  - RUN = 3: hold all resets released and `ready` at 1.
  - If `NUM_STAGES` is 1, STABLE goes straight to RUN and `ready` rises with bit 0.
- Lock loss: if `lock_s` is 0 in STABLE, RELEASE or RUN:
  - next edge: state goes to IDLE, every `rst_stage_n` bit goes to 0, `ready` goes to 0, and all counters clear;
  - `lock_loss_cnt` increments by 1 on every 1→0 transition of `lock_s` in any state, and saturates at all-ones.
- Soft reset: if `soft_rst` is 1 in STABLE, RELEASE or RUN and `lock_s` is 1:
  - next edge: all resets assert, `ready` goes to 0, state goes to STABLE with the count at 0;
  - `lock_loss_cnt` is unchanged;
  - `soft_rst` in IDLE is ignored.
- Simultaneous lock loss and `soft_rst`: lock loss wins (state goes to IDLE).
- Once released, reset bits stay released until lock loss, soft reset or `rst_n`. They are never released out of order.

## Timing
- Values while `rst_n` is asserted, and immediately after it is deasserted:
  - `rst_stage_n` = all 0, `ready` = 0, `state` = IDLE, `lock_loss_cnt` = 0;
  - synchroniser flops = 0.
- All outputs are registered; there are no combinational paths from input to output.
- Latency from `pll_locked` rising to `lock_s` = `SYNC_STAGES` edges. Let T0 be the first cycle in STABLE.
- `rst_stage_n[k]` rises at the edge T0 + `LOCK_STABLE_CYC` + k·`STAGE_GAP_CYC`.
- `ready` rises at T0 + `LOCK_STABLE_CYC` + (`NUM_STAGES`-1)·`STAGE_GAP_CYC`.
- Lock loss to reset asserted: `SYNC_STAGES` + 1 edges after `pll_locked` falls.
- A `lock_s` drop of one cycle or more during STABLE restarts the count. It is never paused.
- Lock glitches shorter than one `sys_clk` period may be missed. This is accepted.

## Test plan
All scenarios run at `sys_clk` 200 MHz (5 ns) with `SYNC_STAGES`=2, `LOCK_STABLE_CYC`=8, `STAGE_GAP_CYC`=4, `NUM_STAGES`=3, `CNT_W`=4.
- Power-up: `rst_n`=0 for 100 ns, then 1. `pll_locked` rises at 200 ns, aligned to an edge. → Expect:
  - `rst_stage_n` = 000→001→011→111 at 2+1+8, +4 and +4 edges after the lock edge;
  - `ready`=1 together with bit 2;
  - `state` = 3.
- Unstable lock: `pll_locked` high for 5 cycles, low for 2, then high. → Expect no release until 8 full locked cycles after the re-lock is synchronised, and `lock_loss_cnt`=1.
- Loss in RUN: drop `pll_locked` while `state`=3. → Expect:
  - `rst_stage_n`=000 and `ready`=0 exactly 3 edges later;
  - `lock_loss_cnt` incremented by 1;
  - the sequence replays when lock returns.
- Soft reset mid-RELEASE: pulse `soft_rst` 1 cycle after bit 0 is released. → Expect all bits back to 0 next edge, `state`=1, the full sequence replayed, and `lock_loss_cnt` unchanged.
- Simultaneous events and saturation:
  - `soft_rst` asserted on the same cycle `lock_s` falls → Expect `state`=0.
  - 20 lock losses → Expect `lock_loss_cnt` to hold at 15.
- Async reset mid-sequence: assert `rst_n` between clock edges in RELEASE. → Expect all outputs at their reset values immediately, without waiting for an edge.
